// File: rtl/alu_cmd_sequencer_if.sv
// Command, response and ALU-side signal bundle for alu_cmd_sequencer.
// Handshakes: a transfer happens on a rising clk edge where valid && ready are both high.
interface alu_cmd_sequencer_if #(
    parameter int DATA_W = 4,
    parameter int RIDX_W = 2
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [RIDX_W-1:0] cmd_rd;
    logic [RIDX_W-1:0] cmd_rs1;
    logic [RIDX_W-1:0] cmd_rs2;
    logic              cmd_use_imm;
    logic [DATA_W-1:0] cmd_imm;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [2:0]        alu_op;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              alu_overflow;
    logic              alu_zero;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_carry;
    logic              rsp_overflow;
    logic              rsp_zero;

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_use_imm, cmd_imm,
        output cmd_ready,
        output alu_a, alu_b, alu_op,
        input  alu_result, alu_carry, alu_overflow, alu_zero,
        output rsp_valid, rsp_result, rsp_carry, rsp_overflow, rsp_zero,
        input  rsp_ready
    );

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_use_imm, cmd_imm,
        input  cmd_ready,
        input  alu_a, alu_b, alu_op,
        output alu_result, alu_carry, alu_overflow, alu_zero,
        input  rsp_valid, rsp_result, rsp_carry, rsp_overflow, rsp_zero,
        output rsp_ready
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// One-at-a-time command front-end for alu_4bit: register-file operand fetch,
// result/flag capture with writeback, and a held valid/ready response.
module alu_cmd_sequencer #(
    parameter  int DATA_W = 4,
    parameter  int NREGS  = 4,
    localparam int RIDX_W = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_cmd_sequencer_if.slave   bus,
    output logic [1:0]           dbg_state_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] rf_q [NREGS];
    logic [DATA_W-1:0] rf_d [NREGS];
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [2:0]        alu_op_q, alu_op_d;
    logic [RIDX_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic              rsp_carry_q, rsp_carry_d;
    logic              rsp_overflow_q, rsp_overflow_d;
    logic              rsp_zero_q, rsp_zero_d;

    always_comb begin
        state_d        = state_q;
        rf_d           = rf_q;
        alu_a_d        = alu_a_q;
        alu_b_d        = alu_b_q;
        alu_op_d       = alu_op_q;
        rd_d           = rd_q;
        rsp_result_d   = rsp_result_q;
        rsp_carry_d    = rsp_carry_q;
        rsp_overflow_d = rsp_overflow_q;
        rsp_zero_d     = rsp_zero_q;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    alu_a_d  = rf_q[bus.cmd_rs1];
                    alu_b_d  = bus.cmd_use_imm ? bus.cmd_imm : rf_q[bus.cmd_rs2];
                    alu_op_d = bus.cmd_op;
                    rd_d     = bus.cmd_rd;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                rsp_result_d   = bus.alu_result;
                rsp_carry_d    = bus.alu_carry;
                rsp_overflow_d = bus.alu_overflow;
                rsp_zero_d     = bus.alu_zero;
                if (rd_q != '0) rf_d[rd_q] = bus.alu_result;
                state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // r0 is a constant zero source, so writes to it never stick.
        rf_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            alu_op_q       <= '0;
            rd_q           <= '0;
            rsp_result_q   <= '0;
            rsp_carry_q    <= 1'b0;
            rsp_overflow_q <= 1'b0;
            rsp_zero_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            rf_q           <= rf_d;
            alu_a_q        <= alu_a_d;
            alu_b_q        <= alu_b_d;
            alu_op_q       <= alu_op_d;
            rd_q           <= rd_d;
            rsp_result_q   <= rsp_result_d;
            rsp_carry_q    <= rsp_carry_d;
            rsp_overflow_q <= rsp_overflow_d;
            rsp_zero_q     <= rsp_zero_d;
        end
    end

    // Handshake outputs decode straight from state so reset drops rsp_valid at once.
    assign bus.cmd_ready    = (state_q == IDLE);
    assign bus.rsp_valid    = (state_q == RESP);
    assign bus.alu_a        = alu_a_q;
    assign bus.alu_b        = alu_b_q;
    assign bus.alu_op       = alu_op_q;
    assign bus.rsp_result   = rsp_result_q;
    assign bus.rsp_carry    = rsp_carry_q;
    assign bus.rsp_overflow = rsp_overflow_q;
    assign bus.rsp_zero     = rsp_zero_q;
    assign dbg_state_o      = state_q;
endmodule
